banana_drop_ctrl: RTL and testbench
===================================

// Module: banana_drop_ctrl
// PURPOSE
//  Sequencer for the 16x16 banana sprite generator. Loads sprite RAM from a 1-cycle-latency ROM.
//  Then drives sprite origin (x0,y0) and ctrl once per frame: fall, respawn, hit animation.
//  Sits between game logic (run/speed/hit) and the sprite datapath (we/addr_w/pixel, x0/y0/ctrl).
// PARAMETERS
//  ADDR       10   sprite RAM address width; load length = 2**ADDR words
//  CD         12   pixel/colour width written to sprite RAM
//  SCR_H      640  visible width in pixels
//  SCR_V      480  visible height in pixels; y0 = SCR_V means sprite off-screen
//  START_X    312  x0 of first spawn after reset/load
//  LANE_STEP  96   x0 increment per respawn, wraps modulo (SCR_H-16)
//  HIT_FRAMES 12   frames the hit frame (sid 3) is held
// PORTS
//  clk         in   1     system clock
//  reset       in   1     asynchronous, active-high reset
//  x, y        in   11    current pixel coordinates from sync generator
//  load_start  in   1     1-cycle pulse: (re)load sprite RAM from ROM
//  load_busy   out  1     high while LOAD state active
//  rom_addr    out  ADDR  sprite ROM read address
//  rom_data    in   CD    ROM data, valid 1 clk after rom_addr
//  we          out  1     sprite RAM write enable
//  addr_w      out  ADDR  sprite RAM write address
//  pixel_out   out  CD    sprite RAM write data
//  run         in   1     level: game active
//  speed       in   3     pixels per frame fall step; 0 treated as 1
//  hit         in   1     1-cycle pulse: player struck banana
//  x0, y0      out  11    sprite origin
//  ctrl        out  5     {2'b00, auto, sid[1:0]} to sprite datapath
//  score       out  8     hits, saturating at 255
//  misses      out  8     bananas reaching bottom, saturating at 255
//  miss        out  1     1-cycle pulse on each miss
// BEHAVIOUR
//  Reset values: state IDLE, x0=START_X, y0=SCR_V, ctrl=0, we=0, addr_w=0, rom_addr=0,
//   pixel_out=0, load_busy=0, score=0, misses=0, miss=0. All outputs registered.
//  frame_tick: x_d1==0 && x==1 && y==0, where x_d1 = x delayed 1 clk. Same definition as datapath.
//  IDLE: y0=SCR_V, ctrl=0. load_start -> LOAD.
//  LOAD: cnt 0..2**ADDR-1 drives rom_addr. Next clk: we=1, addr_w=cnt_d1, pixel_out=rom_data.
//   Exactly 2**ADDR writes. After the last write (we drops), go to WAIT.
//   load_busy=1 from the clk after load_start through the last write. load_start inside LOAD is ignored.
//  WAIT: y0=SCR_V, ctrl=0. On frame_tick with run=1: y0<=0, x0 kept, -> FALL.
//  FALL: ctrl={2'b00,1'b1,2'b00} (auto animation).
//   On each frame_tick: step = (speed==0)?1:speed.
//   If y0+step > SCR_V-16: miss pulse, misses++ (sat). Respawn: y0<=0, x0<=next lane.
//   Else y0 <= y0+step.
//  Next lane: x0+LANE_STEP; if >= SCR_H-16, subtract (SCR_H-16).
//  Priority in FALL: reset > load_start > hit > run=0 > frame step.
//  hit in FALL: score++ (sat), -> HIT, hcnt=0. hit outside FALL is ignored.
//  HIT: ctrl={2'b00,1'b0,2'b11}, y0 frozen. hcnt++ per frame_tick.
//   At hcnt==HIT_FRAMES-1 with frame_tick: respawn (y0=0, next lane) -> FALL if run, else WAIT (y0=SCR_V).
//  run=0 in FALL/HIT: next clk -> WAIT, y0=SCR_V.
//  load_start in WAIT/FALL/HIT: y0=SCR_V, -> LOAD. score/misses kept.
//  Simultaneous hit and miss condition on one frame_tick: hit wins, no miss.
//  Width rules: y0+step computed 12 bit unsigned; lane sum 12 bit. No wrap past SCR_V is possible.
//  Async reset mid-LOAD: we drops immediately; the RAM keeps a partial image until the next load.
// STRUCTURE
//  Package banana_ctrl_pkg: typedef enum logic [2:0] {IDLE,LOAD,WAIT,FALL,HIT} state_t.
//   Also constants SID_HIT=2'b11, CTRL_AUTO, CTRL_OFF.
//  Sub-module frame_tick_gen (x_d1 register + compare), reusable by other sprite controllers.
//  Main module: FSM, load counter with 1-clk write pipeline, origin/lane regs, hit counter, score counters.
// TESTING
//  Load: pulse load_start, ROM returns addr^12'h5A5.
//   -> 1024 writes, addr_w 0..1023 in order, pixel_out = addr^5A5, load_busy falls after write 1023.
//  Fall: run=1, speed=4. After first frame_tick y0=0; after 116 more ticks y0=464.
//   Next tick -> miss pulse, misses=1, y0=0, x0=408.
//  speed=0 -> y0 advances by 1 per frame. Lane wrap: x0=600 respawn -> x0=72.
//  Hit: hit pulse at y0=200 -> score=1, ctrl=5'b00011, y0 held 200 for 12 frame_ticks, then y0=0, ctrl=5'b00100.
//  run=0 during HIT -> next clk WAIT, y0=480, ctrl=0. Hit pulse in WAIT -> score unchanged.
//  Async reset asserted mid-LOAD (cnt=300) -> we=0 same cycle, all reset values.
//   Score saturation: 260 hits -> score=255.

Source files
------------

// File: rtl/banana_ctrl_pkg.sv
// Shared types and constants for the banana sprite controller.
//   state_t   : sequencer states
//   SID_HIT   : sprite id of the hit frame
//   CTRL_*    : ctrl words driven to the sprite datapath
//   sat_inc8  : saturating 8-bit increment used by score/miss counters
package banana_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, FALL, HIT} state_t;

  localparam logic [1:0] SID_HIT   = 2'b11;
  localparam logic [4:0] CTRL_OFF  = 5'b00000;
  localparam logic [4:0] CTRL_AUTO = 5'b00100;
  localparam logic [4:0] CTRL_HIT  = {3'b000, SID_HIT};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame strobe derived from the sync generator coordinates.
//   clk, reset : clock, async active-high reset
//   x, y       : current pixel coordinates
//   tick       : high in the cycle where x steps 0 -> 1 on line 0
module frame_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [10:0] y,
  output logic        tick
);

  logic [10:0] x_d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) x_d1 <= '0;
    else       x_d1 <= x;
  end

  assign tick = (x_d1 == 11'd0) && (x == 11'd1) && (y == 11'd0);

endmodule

// File: rtl/banana_drop_ctrl.sv
// Banana sprite sequencer: loads sprite RAM from a 1-cycle-latency ROM, then
// moves the sprite origin once per frame (fall, respawn, hit animation).
//   clk, reset          : clock, async active-high reset
//   x, y                : pixel coordinates (frame tick source)
//   load_start/load_busy: RAM load request / load in progress
//   rom_addr, rom_data  : sprite ROM read port (data valid 1 clk after addr)
//   we, addr_w, pixel_out: sprite RAM write port
//   run, speed, hit     : game control inputs
//   x0, y0, ctrl        : sprite origin and datapath control
//   score, misses, miss : saturating counters and miss strobe
module banana_drop_ctrl
  import banana_ctrl_pkg::*;
#(
  parameter int ADDR       = 10,
  parameter int CD         = 12,
  parameter int SCR_H      = 640,
  parameter int SCR_V      = 480,
  parameter int START_X    = 312,
  parameter int LANE_STEP  = 96,
  parameter int HIT_FRAMES = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [10:0]     x,
  input  logic [10:0]     y,
  input  logic            load_start,
  output logic            load_busy,
  output logic [ADDR-1:0] rom_addr,
  input  logic [CD-1:0]   rom_data,
  output logic            we,
  output logic [ADDR-1:0] addr_w,
  output logic [CD-1:0]   pixel_out,
  input  logic            run,
  input  logic [2:0]      speed,
  input  logic            hit,
  output logic [10:0]     x0,
  output logic [10:0]     y0,
  output logic [4:0]      ctrl,
  output logic [7:0]      score,
  output logic [7:0]      misses,
  output logic            miss
);

  localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam logic [10:0]     Y_OFF     = 11'(SCR_V);
  localparam logic [10:0]     X_START   = 11'(START_X);
  localparam logic [11:0]     Y_LIM     = 12'(SCR_V - 16);
  localparam logic [11:0]     LANE_W    = 12'(SCR_H - 16);
  localparam logic [11:0]     LANE_S    = 12'(LANE_STEP);
  localparam logic [ADDR-1:0] ADDR_LAST = '1;
  localparam logic [HW-1:0]   HCNT_LAST = HW'(HIT_FRAMES - 1);

  logic            frame_tick;
  state_t          state, state_n;
  logic [10:0]     x0_n, y0_n;
  logic [4:0]      ctrl_n;
  logic [7:0]      score_n, misses_n;
  logic            miss_n, load_busy_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [ADDR-1:0] rom_addr_n;
  logic            issue_done, issue_done_n;
  // stage between ROM address and RAM write: rom_data belongs to cnt_d1
  logic            v1;
  logic [ADDR-1:0] cnt_d1;
  logic [2:0]      step;
  logic [11:0]     ysum, lane_sum;
  logic [10:0]     lane_x;

  frame_tick_gen u_tick (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .tick  (frame_tick)
  );

  always_comb begin
    state_n      = state;
    x0_n         = x0;
    y0_n         = y0;
    score_n      = score;
    misses_n     = misses;
    miss_n       = 1'b0;
    hcnt_n       = hcnt;
    rom_addr_n   = rom_addr;
    issue_done_n = issue_done;
    load_busy_n  = load_busy;
    ctrl_n       = CTRL_OFF;

    step     = (speed == 3'd0) ? 3'd1 : speed;
    ysum     = {1'b0, y0} + {9'b0, step};
    lane_sum = {1'b0, x0} + LANE_S;
    lane_x   = (lane_sum >= LANE_W) ? 11'(lane_sum - LANE_W) : lane_sum[10:0];

    if (load_start && state != LOAD) begin
      state_n      = LOAD;
      rom_addr_n   = '0;
      issue_done_n = 1'b0;
      load_busy_n  = 1'b1;
      y0_n         = Y_OFF;
    end else begin
      case (state)
        LOAD: begin
          if (!issue_done) begin
            if (rom_addr == ADDR_LAST) issue_done_n = 1'b1;
            else                       rom_addr_n   = rom_addr + ADDR'(1);
          end
          // final write is on the bus now and nothing is left in the pipeline
          if (issue_done && we && !v1) begin
            state_n     = WAIT;
            load_busy_n = 1'b0;
          end
        end
        WAIT: begin
          if (frame_tick && run) begin
            y0_n    = '0;
            state_n = FALL;
          end
        end
        FALL: begin
          if (hit) begin
            score_n = sat_inc8(score);
            hcnt_n  = '0;
            state_n = HIT;
          end else if (!run) begin
            y0_n    = Y_OFF;
            state_n = WAIT;
          end else if (frame_tick) begin
            if (ysum > Y_LIM) begin
              miss_n   = 1'b1;
              misses_n = sat_inc8(misses);
              y0_n     = '0;
              x0_n     = lane_x;
            end else begin
              y0_n = ysum[10:0];
            end
          end
        end
        HIT: begin
          if (!run) begin
            y0_n    = Y_OFF;
            state_n = WAIT;
          end else if (frame_tick) begin
            if (hcnt == HCNT_LAST) begin
              y0_n    = '0;
              x0_n    = lane_x;
              state_n = FALL;
            end else begin
              hcnt_n = hcnt + HW'(1);
            end
          end
        end
        default: ;
      endcase
    end

    case (state_n)
      FALL:    ctrl_n = CTRL_AUTO;
      HIT:     ctrl_n = CTRL_HIT;
      default: ctrl_n = CTRL_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      x0         <= X_START;
      y0         <= Y_OFF;
      ctrl       <= CTRL_OFF;
      score      <= '0;
      misses     <= '0;
      miss       <= 1'b0;
      hcnt       <= '0;
      rom_addr   <= '0;
      issue_done <= 1'b0;
      load_busy  <= 1'b0;
      v1         <= 1'b0;
      cnt_d1     <= '0;
      we         <= 1'b0;
      addr_w     <= '0;
      pixel_out  <= '0;
    end else begin
      state      <= state_n;
      x0         <= x0_n;
      y0         <= y0_n;
      ctrl       <= ctrl_n;
      score      <= score_n;
      misses     <= misses_n;
      miss       <= miss_n;
      hcnt       <= hcnt_n;
      rom_addr   <= rom_addr_n;
      issue_done <= issue_done_n;
      load_busy  <= load_busy_n;
      v1         <= (state == LOAD) && !issue_done;
      cnt_d1     <= rom_addr;
      we         <= v1;
      if (v1) begin
        addr_w    <= cnt_d1;
        pixel_out <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_banana_drop_ctrl.sv
module tb_banana_drop_ctrl;

  logic        clk = 1'b0;
  logic        reset, load_start, run, hit;
  logic [10:0] x, y, x0, y0;
  logic [2:0]  speed;
  logic        load_busy, we, miss;
  logic [9:0]  rom_addr, addr_w;
  logic [11:0] rom_data, pixel_out;
  logic [4:0]  ctrl;
  logic [7:0]  score, misses;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ROM with one clock of read latency
  always @(posedge clk) rom_data <= {2'b00, rom_addr} ^ 12'h5A5;

  banana_drop_ctrl #(
    .ADDR(10), .CD(12), .SCR_H(640), .SCR_V(480),
    .START_X(312), .LANE_STEP(96), .HIT_FRAMES(12)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .load_start(load_start), .load_busy(load_busy),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .we(we), .addr_w(addr_w), .pixel_out(pixel_out),
    .run(run), .speed(speed), .hit(hit),
    .x0(x0), .y0(y0), .ctrl(ctrl),
    .score(score), .misses(misses), .miss(miss)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_tick(input logic with_hit);
    x = 11'd0; y = 11'd0;
    tick();
    x = 11'd1; hit = with_hit;
    tick();
    hit = 1'b0; x = 11'd2; y = 11'd5;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start = 1'b0; run = 1'b0; hit = 1'b0;
    speed = 3'd0; x = 11'd100; y = 11'd5;
    repeat (3) tick();
    vectors++;
    if ({x0, y0, ctrl, score, misses} !== {11'd312, 11'd480, 5'd0, 8'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_origin: got x0=%0d y0=%0d ctrl=%b score=%0d misses=%0d want 312 480 00000 0 0",
               x0, y0, ctrl, score, misses);
    end
    vectors++;
    if ({we, load_busy, miss, rom_addr, addr_w, pixel_out} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_ports: got we=%b busy=%b miss=%b rom_addr=%0d addr_w=%0d pix=%h want all 0",
               we, load_busy, miss, rom_addr, addr_w, pixel_out);
    end
    #2 reset = 1'b0;
    tick();
    run = 1'b1;
    frame_tick(1'b0);
    vectors++;
    if ({y0, ctrl} !== {11'd480, 5'd0}) begin
      miscompares++;
      $display("FAIL idle_ignores_run: got y0=%0d ctrl=%b want 480 00000", y0, ctrl);
    end
    run = 1'b0;
  endtask

  task automatic test_load();
    int n;
    logic done;
    logic [9:0] ea;
    n = 0; done = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    vectors++;
    if ({load_busy, we} !== 2'b10) begin
      miscompares++;
      $display("FAIL load_busy_rise: got busy=%b we=%b want 1 0", load_busy, we);
    end
    for (int c = 0; c < 1100 && !done; c++) begin
      load_start = (c == 500);
      tick();
      if (we) begin
        ea = n[9:0];
        vectors++;
        if ({addr_w, pixel_out} !== {ea, {2'b00, ea} ^ 12'h5A5}) begin
          miscompares++;
          $display("FAIL load_write: got addr_w=%0d pix=%h want %0d %h",
                   addr_w, pixel_out, ea, {2'b00, ea} ^ 12'h5A5);
        end
        if (n == 1023) begin
          vectors++;
          if (load_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_busy_last: got %b want 1", load_busy);
          end
        end
        n++;
      end
      if (!load_busy) done = 1'b1;
    end
    load_start = 1'b0;
    vectors++;
    if ({done, we} !== 2'b10 || n != 1024) begin
      miscompares++;
      $display("FAIL load_end: got done=%b we=%b writes=%0d want 1 0 1024", done, we, n);
    end
    vectors++;
    if ({y0, ctrl} !== {11'd480, 5'd0}) begin
      miscompares++;
      $display("FAIL load_wait_state: got y0=%0d ctrl=%b want 480 00000", y0, ctrl);
    end
  endtask

  task automatic test_fall();
    run = 1'b1; speed = 3'd4;
    frame_tick(1'b0);
    vectors++;
    if ({x0, y0, ctrl} !== {11'd312, 11'd0, 5'b00100}) begin
      miscompares++;
      $display("FAIL fall_start: got x0=%0d y0=%0d ctrl=%b want 312 0 00100", x0, y0, ctrl);
    end
    repeat (116) frame_tick(1'b0);
    vectors++;
    if ({y0, misses, miss} !== {11'd464, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL fall_bottom: got y0=%0d misses=%0d miss=%b want 464 0 0", y0, misses, miss);
    end
    frame_tick(1'b0);
    vectors++;
    if ({miss, misses, y0, x0} !== {1'b1, 8'd1, 11'd0, 11'd408}) begin
      miscompares++;
      $display("FAIL fall_miss: got miss=%b misses=%0d y0=%0d x0=%0d want 1 1 0 408",
               miss, misses, y0, x0);
    end
    tick();
    vectors++;
    if (miss !== 1'b0) begin
      miscompares++;
      $display("FAIL miss_pulse_width: got %b want 0", miss);
    end
  endtask

  task automatic test_speed0();
    speed = 3'd0;
    frame_tick(1'b0);
    vectors++;
    if (y0 !== 11'd1) begin
      miscompares++;
      $display("FAIL speed0_step1: got y0=%0d want 1", y0);
    end
    frame_tick(1'b0);
    vectors++;
    if (y0 !== 11'd2) begin
      miscompares++;
      $display("FAIL speed0_step2: got y0=%0d want 2", y0);
    end
  endtask

  task automatic test_hit();
    speed = 3'd6;
    repeat (33) frame_tick(1'b0);
    vectors++;
    if (y0 !== 11'd200) begin
      miscompares++;
      $display("FAIL hit_setup: got y0=%0d want 200", y0);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    vectors++;
    if ({score, ctrl, y0} !== {8'd1, 5'b00011, 11'd200}) begin
      miscompares++;
      $display("FAIL hit_enter: got score=%0d ctrl=%b y0=%0d want 1 00011 200", score, ctrl, y0);
    end
    for (int i = 0; i < 11; i++) begin
      frame_tick(1'b0);
      vectors++;
      if ({y0, ctrl} !== {11'd200, 5'b00011}) begin
        miscompares++;
        $display("FAIL hit_hold: got y0=%0d ctrl=%b want 200 00011 (tick %0d)", y0, ctrl, i + 1);
      end
    end
    frame_tick(1'b0);
    vectors++;
    if ({y0, ctrl, x0} !== {11'd0, 5'b00100, 11'd504}) begin
      miscompares++;
      $display("FAIL hit_respawn: got y0=%0d ctrl=%b x0=%0d want 0 00100 504", y0, ctrl, x0);
    end
  endtask

  task automatic test_lane_wrap();
    hit = 1'b1;
    tick();
    hit = 1'b0;
    repeat (12) frame_tick(1'b0);
    vectors++;
    if ({x0, y0, score} !== {11'd600, 11'd0, 8'd2}) begin
      miscompares++;
      $display("FAIL lane_600: got x0=%0d y0=%0d score=%0d want 600 0 2", x0, y0, score);
    end
    speed = 3'd7;
    repeat (66) frame_tick(1'b0);
    vectors++;
    if ({y0, misses} !== {11'd462, 8'd1}) begin
      miscompares++;
      $display("FAIL speed7_edge: got y0=%0d misses=%0d want 462 1", y0, misses);
    end
    frame_tick(1'b0);
    vectors++;
    if ({miss, misses, x0, y0} !== {1'b1, 8'd2, 11'd72, 11'd0}) begin
      miscompares++;
      $display("FAIL lane_wrap: got miss=%b misses=%0d x0=%0d y0=%0d want 1 2 72 0",
               miss, misses, x0, y0);
    end
  endtask

  task automatic test_hit_miss_same_tick();
    repeat (66) frame_tick(1'b0);
    frame_tick(1'b1);
    vectors++;
    if ({score, misses, miss, y0, ctrl, x0} !== {8'd3, 8'd2, 1'b0, 11'd462, 5'b00011, 11'd72}) begin
      miscompares++;
      $display("FAIL hit_beats_miss: got score=%0d misses=%0d miss=%b y0=%0d ctrl=%b x0=%0d want 3 2 0 462 00011 72",
               score, misses, miss, y0, ctrl, x0);
    end
  endtask

  task automatic test_run_low();
    run = 1'b0;
    tick();
    vectors++;
    if ({y0, ctrl} !== {11'd480, 5'd0}) begin
      miscompares++;
      $display("FAIL run_low_wait: got y0=%0d ctrl=%b want 480 00000", y0, ctrl);
    end
    hit = 1'b1;
    tick();
    hit = 1'b0;
    frame_tick(1'b0);
    vectors++;
    if ({score, y0, ctrl} !== {8'd3, 11'd480, 5'd0}) begin
      miscompares++;
      $display("FAIL hit_in_wait: got score=%0d y0=%0d ctrl=%b want 3 480 00000", score, y0, ctrl);
    end
  endtask

  task automatic test_score_sat();
    for (int i = 0; i < 260; i++) begin
      run = 1'b1;
      frame_tick(1'b0);
      hit = 1'b1;
      tick();
      hit = 1'b0; run = 1'b0;
      tick();
      if (i == 250) begin
        vectors++;
        if (score !== 8'd254) begin
          miscompares++;
          $display("FAIL score_254: got %0d want 254", score);
        end
      end
    end
    vectors++;
    if ({score, ctrl} !== {8'd255, 5'd0}) begin
      miscompares++;
      $display("FAIL score_sat: got score=%0d ctrl=%b want 255 00000", score, ctrl);
    end
  endtask

  task automatic test_reset_mid_load();
    run = 1'b1;
    frame_tick(1'b0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    vectors++;
    if ({load_busy, y0, ctrl, score, misses} !== {1'b1, 11'd480, 5'd0, 8'd255, 8'd2}) begin
      miscompares++;
      $display("FAIL load_from_fall: got busy=%b y0=%0d ctrl=%b score=%0d misses=%0d want 1 480 00000 255 2",
               load_busy, y0, ctrl, score, misses);
    end
    repeat (302) tick();
    vectors++;
    if ({we, addr_w} !== {1'b1, 10'd300}) begin
      miscompares++;
      $display("FAIL mid_load_pos: got we=%b addr_w=%0d want 1 300", we, addr_w);
    end
    #3 reset = 1'b1;
    #1;
    vectors++;
    if ({we, load_busy, miss, addr_w, rom_addr, pixel_out} !== 35'd0) begin
      miscompares++;
      $display("FAIL async_reset_ports: got we=%b busy=%b miss=%b addr_w=%0d rom_addr=%0d pix=%h want all 0",
               we, load_busy, miss, addr_w, rom_addr, pixel_out);
    end
    vectors++;
    if ({x0, y0, ctrl, score, misses} !== {11'd312, 11'd480, 5'd0, 8'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL async_reset_state: got x0=%0d y0=%0d ctrl=%b score=%0d misses=%0d want 312 480 00000 0 0",
               x0, y0, ctrl, score, misses);
    end
    #10 reset = 1'b0;
    run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_fall();
    test_speed0();
    test_hit();
    test_lane_wrap();
    test_hit_miss_same_tick();
    test_run_low();
    test_score_sat();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
